// File: rtl/titan_pipe_pkg.sv
// Shared types and constants for the pipeline control unit: FSM state
// encoding, forwarding-select codes and the register-address width.
package titan_pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 32;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } pipe_state_t;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // The younger producer (MEM) holds the newer value, so it wins over WB.
  function automatic logic [1:0] fwd_select(input logic mem_hit, input logic wb_hit);
    if (mem_hit) return FWD_MEM;
    if (wb_hit)  return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipectrl_raw_match.sv
// Read-after-write detector for one producer stage against one ID source.
// Register x0 is hardwired to zero, so a write to it never creates a dependence.
module pipectrl_raw_match
  import titan_pipe_pkg::*;
(
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  src_used,
  output logic                  match
);

  // A source depends on the producer only if it is really read and the producer really writes it.
  assign match = we & src_used & (waddr != '0) & (waddr == src);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and pipeline-control unit for the five-stage core: stage-register
// stall/flush controls, EX operand-forwarding selects, exception redirect
// sequencing and a stall-cycle counter.
// Optional feature macro: PIPECTRL_FWD_EN. When defined, MEM/WB results are
// bypassed into EX and only load-use dependences stall. When undefined, the
// selects are tied to the register file and any in-flight producer stalls ID.
module pipeline_ctrl
  import titan_pipe_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_waddr,
  input  logic [REG_ADDR_W-1:0] mem_waddr,
  input  logic [REG_ADDR_W-1:0] wb_waddr,
  input  logic                  ex_we,
  input  logic                  mem_we,
  input  logic                  wb_we,
  input  logic                  ex_load,
  input  logic                  ex_take_branch,
  input  logic                  mem_exc,
  input  logic                  imem_stall,
  input  logic                  dmem_stall,
  output logic                  pc_stall,
  output logic                  ifid_stall,
  output logic                  idex_stall,
  output logic                  exmem_stall,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic                  memwb_flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  pc_sel_exc,
  output logic [CNT_W-1:0]      stall_cycles
);

  pipe_state_t state;
  pipe_state_t next_state;

  logic ex_rs1_hit, ex_rs2_hit;
  logic mem_rs1_hit, mem_rs2_hit;
  logic wb_rs1_hit, wb_rs2_hit;
  logic ex_dep, late_dep, raw_stall;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  pipectrl_raw_match u_ex_rs1 (
    .we(ex_we), .waddr(ex_waddr), .src(id_rs1), .src_used(id_use_rs1), .match(ex_rs1_hit)
  );
  pipectrl_raw_match u_ex_rs2 (
    .we(ex_we), .waddr(ex_waddr), .src(id_rs2), .src_used(id_use_rs2), .match(ex_rs2_hit)
  );
  pipectrl_raw_match u_mem_rs1 (
    .we(mem_we), .waddr(mem_waddr), .src(id_rs1), .src_used(id_use_rs1), .match(mem_rs1_hit)
  );
  pipectrl_raw_match u_mem_rs2 (
    .we(mem_we), .waddr(mem_waddr), .src(id_rs2), .src_used(id_use_rs2), .match(mem_rs2_hit)
  );
  pipectrl_raw_match u_wb_rs1 (
    .we(wb_we), .waddr(wb_waddr), .src(id_rs1), .src_used(id_use_rs1), .match(wb_rs1_hit)
  );
  pipectrl_raw_match u_wb_rs2 (
    .we(wb_we), .waddr(wb_waddr), .src(id_rs2), .src_used(id_use_rs2), .match(wb_rs2_hit)
  );

`ifdef PIPECTRL_FWD_EN
  localparam logic BYPASS_EN = 1'b1;
  assign fwd_a_raw = fwd_select(mem_rs1_hit, wb_rs1_hit);
  assign fwd_b_raw = fwd_select(mem_rs2_hit, wb_rs2_hit);
`else
  localparam logic BYPASS_EN = 1'b0;
  assign fwd_a_raw = FWD_RF;
  assign fwd_b_raw = FWD_RF;
`endif

  // With bypassing only a load in EX is too late to forward; without it every
  // in-flight producer must reach the register file before ID may proceed.
  assign ex_dep    = (ex_rs1_hit | ex_rs2_hit) & (ex_load | ~BYPASS_EN);
  assign late_dep  = ~BYPASS_EN & (mem_rs1_hit | mem_rs2_hit | wb_rs1_hit | wb_rs2_hit);
  assign raw_stall = ex_dep | late_dep;

  // Decode the control outputs and next state from the current state and hazards; all quiet in reset.
  always_comb begin
    next_state  = state;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_stall  = 1'b0;
    exmem_stall = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    pc_sel_exc  = 1'b0;
    fwd_a_sel   = FWD_RF;
    fwd_b_sel   = FWD_RF;
    if (rst_n) begin
      fwd_a_sel = fwd_a_raw;
      fwd_b_sel = fwd_b_raw;
      case (state)
        RUN: begin
          if (mem_exc) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            next_state  = dmem_stall ? DRAIN : REDIRECT;
          end else if (dmem_stall) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_flush = 1'b1;
          end else if (ex_take_branch) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (raw_stall) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
          end else if (imem_stall) begin
            pc_stall   = 1'b1;
            ifid_flush = 1'b1;
          end
        end
        DRAIN: begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          memwb_flush = 1'b1;
          if (!dmem_stall) next_state = REDIRECT;
        end
        REDIRECT: begin
          pc_sel_exc = 1'b1;
          ifid_flush = 1'b1;
          next_state = RUN;
        end
        default: next_state = RUN;
      endcase
    end
  end

  // Advance the exception-sequencing state machine.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= next_state;
  end

  // Count every cycle the PC is held; wraps naturally and only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n)        stall_cycles <= '0;
    else if (pc_stall) stall_cycles <= stall_cycles + 32'd1;
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: directed scenarios plus randomized traffic
// checked against a rule-level reference model. Honours PIPECTRL_FWD_EN.
module tb_pipeline_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_waddr, mem_waddr, wb_waddr;
  logic       id_use_rs1, id_use_rs2;
  logic       ex_we, mem_we, wb_we, ex_load, ex_take_branch, mem_exc;
  logic       imem_stall, dmem_stall;
  logic       pc_stall, ifid_stall, idex_stall, exmem_stall;
  logic       ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       pc_sel_exc;
  logic [31:0] stall_cycles;

  logic [12:0] obs;
  logic [12:0] exp_v;

  int vectors;
  int miscompares;

  localparam int PH_FLOW  = 0;
  localparam int PH_DRAIN = 1;
  localparam int PH_TRAP  = 2;
  int          m_phase;
  logic [31:0] m_stalls;

  pipeline_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_waddr(ex_waddr), .mem_waddr(mem_waddr), .wb_waddr(wb_waddr),
    .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we), .ex_load(ex_load),
    .ex_take_branch(ex_take_branch), .mem_exc(mem_exc),
    .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall), .exmem_stall(exmem_stall),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .pc_sel_exc(pc_sel_exc),
    .stall_cycles(stall_cycles)
  );

  assign obs = {pc_stall, ifid_stall, idex_stall, exmem_stall,
                ifid_flush, idex_flush, exmem_flush, memwb_flush,
                pc_sel_exc, fwd_a_sel, fwd_b_sel};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Does a producer write a register that ID really reads?
  function automatic bit reads(input logic we, input logic [4:0] wa, input logic [4:0] src, input logic used);
    return (we === 1'b1) && (wa != 5'd0) && (wa == src) && (used === 1'b1);
  endfunction

  // Expected {ctrl[8:0], fwd_a, fwd_b} from the rules and the model phase.
  function automatic logic [12:0] model_outputs();
    logic [8:0] ctl;
    logic [1:0] fa, fb;
    bit a_ex, b_ex, a_mem, b_mem, a_wb, b_wb, dep;
    ctl = '0;
    fa  = 2'd0;
    fb  = 2'd0;
    if (rst_n !== 1'b1) return '0;
    a_ex  = reads(ex_we,  ex_waddr,  id_rs1, id_use_rs1);
    b_ex  = reads(ex_we,  ex_waddr,  id_rs2, id_use_rs2);
    a_mem = reads(mem_we, mem_waddr, id_rs1, id_use_rs1);
    b_mem = reads(mem_we, mem_waddr, id_rs2, id_use_rs2);
    a_wb  = reads(wb_we,  wb_waddr,  id_rs1, id_use_rs1);
    b_wb  = reads(wb_we,  wb_waddr,  id_rs2, id_use_rs2);
`ifdef PIPECTRL_FWD_EN
    dep = (ex_load === 1'b1) && (a_ex || b_ex);
    fa  = a_mem ? 2'd1 : (a_wb ? 2'd2 : 2'd0);
    fb  = b_mem ? 2'd1 : (b_wb ? 2'd2 : 2'd0);
`else
    dep = a_ex || b_ex || a_mem || b_mem || a_wb || b_wb;
`endif
    if (m_phase == PH_DRAIN)        ctl = 9'b0000_1111_0;
    else if (m_phase == PH_TRAP)    ctl = 9'b0000_1000_1;
    else if (mem_exc)               ctl = 9'b0000_1110_0;
    else if (dmem_stall)            ctl = 9'b1111_0001_0;
    else if (ex_take_branch)        ctl = 9'b0000_1100_0;
    else if (dep)                   ctl = 9'b1100_0100_0;
    else if (imem_stall)            ctl = 9'b1000_1000_0;
    return {ctl, fa, fb};
  endfunction

  // Move the model one clock forward using the inputs present at the edge.
  task automatic model_advance();
    logic [12:0] e;
    e = model_outputs();
    if (rst_n !== 1'b1) begin
      m_phase  = PH_FLOW;
      m_stalls = 32'd0;
    end else begin
      if (e[12]) m_stalls = m_stalls + 32'd1;
      if (m_phase == PH_FLOW && mem_exc)          m_phase = dmem_stall ? PH_DRAIN : PH_TRAP;
      else if (m_phase == PH_DRAIN && !dmem_stall) m_phase = PH_TRAP;
      else if (m_phase == PH_TRAP)                 m_phase = PH_FLOW;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_waddr = 0; mem_waddr = 0; wb_waddr = 0;
    ex_we = 0; mem_we = 0; wb_we = 0; ex_load = 0;
    ex_take_branch = 0; mem_exc = 0; imem_stall = 0; dmem_stall = 0;
  endtask

  task automatic random_inputs();
    id_rs1 = 5'($urandom_range(3)); id_rs2 = 5'($urandom_range(3));
    id_use_rs1 = 1'($urandom_range(1)); id_use_rs2 = 1'($urandom_range(1));
    ex_waddr = 5'($urandom_range(3)); mem_waddr = 5'($urandom_range(3)); wb_waddr = 5'($urandom_range(3));
    ex_we = 1'($urandom_range(1)); mem_we = 1'($urandom_range(1)); wb_we = 1'($urandom_range(1));
    ex_load = 1'($urandom_range(1));
    ex_take_branch = ($urandom_range(5) == 0);
    mem_exc = ($urandom_range(15) == 0);
    imem_stall = ($urandom_range(3) == 0);
    dmem_stall = ($urandom_range(3) == 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    random_inputs();
    tick();
    for (int i = 0; i < 3; i++) begin
      random_inputs();
      mem_exc = 1'b1;
      dmem_stall = 1'b1;
      @(negedge clk);
      vectors++;
      if (obs !== 13'd0) begin
        miscompares++;
        $display("[TB] FAIL reset_outputs: got %b want %b", obs, 13'd0);
      end
      vectors++;
      if (stall_cycles !== 32'd0) begin
        miscompares++;
        $display("[TB] FAIL reset_counter: got %0d want 0", stall_cycles);
      end
      tick();
    end
    clear_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    clear_inputs();
    ex_load = 1; ex_we = 1; ex_waddr = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1;
    @(negedge clk);
    vectors++;
    if ({pc_stall, ifid_stall, idex_flush, idex_stall, ifid_flush} !== 5'b11100) begin
      miscompares++;
      $display("[TB] FAIL load_use_bubble: got %b want 11100", {pc_stall, ifid_stall, idex_flush, idex_stall, ifid_flush});
    end
    exp_v = model_outputs();
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("[TB] FAIL load_use_model: got %b want %b", obs, exp_v);
    end
    tick();
    ex_load = 0; ex_we = 0;
    @(negedge clk);
    vectors++;
    if (pc_stall !== 1'b0 || idex_flush !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL load_use_release: got pc_stall=%b idex_flush=%b want 0 0", pc_stall, idex_flush);
    end
    vectors++;
    if (stall_cycles !== 32'd1) begin
      miscompares++;
      $display("[TB] FAIL load_use_count: got %0d want 1", stall_cycles);
    end
    tick();
  endtask

  task automatic test_forwarding();
    logic [1:0] want_b [3];
    logic       want_stall [3];
`ifdef PIPECTRL_FWD_EN
    want_b = '{2'd1, 2'd2, 2'd0};
    want_stall = '{1'b0, 1'b0, 1'b0};
`else
    want_b = '{2'd0, 2'd0, 2'd0};
    want_stall = '{1'b1, 1'b1, 1'b0};
`endif
    clear_inputs();
    mem_we = 1; mem_waddr = 5'd7; wb_we = 1; wb_waddr = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) mem_we = 0;
      if (k == 2) begin mem_waddr = 0; wb_waddr = 0; end
      @(negedge clk);
      vectors++;
      if (fwd_b_sel !== want_b[k] || pc_stall !== want_stall[k]) begin
        miscompares++;
        $display("[TB] FAIL fwd_b_step%0d: got sel=%0d stall=%b want sel=%0d stall=%b",
                 k, fwd_b_sel, pc_stall, want_b[k], want_stall[k]);
      end
      vectors++;
      if (fwd_a_sel !== 2'd0) begin
        miscompares++;
        $display("[TB] FAIL fwd_a_idle_step%0d: got %0d want 0", k, fwd_a_sel);
      end
      tick();
    end
  endtask

  task automatic test_branch_priority();
    clear_inputs();
    ex_take_branch = 1; ex_load = 1; ex_we = 1; ex_waddr = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1;
    @(negedge clk);
    vectors++;
    if ({ifid_flush, idex_flush, pc_stall, ifid_stall} !== 4'b1100) begin
      miscompares++;
      $display("[TB] FAIL branch_over_load_use: got %b want 1100", {ifid_flush, idex_flush, pc_stall, ifid_stall});
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_exception_drain();
    clear_inputs();
    mem_exc = 1; dmem_stall = 1;
    @(negedge clk);
    vectors++;
    if ({ifid_flush, idex_flush, exmem_flush, memwb_flush, pc_stall} !== 5'b11100) begin
      miscompares++;
      $display("[TB] FAIL exc_entry: got %b want 11100", {ifid_flush, idex_flush, exmem_flush, memwb_flush, pc_stall});
    end
    tick();
    for (int c = 1; c <= 3; c++) begin
      mem_exc = 1'($urandom_range(1));
      dmem_stall = (c < 3);
      @(negedge clk);
      vectors++;
      if ({ifid_flush, idex_flush, exmem_flush, memwb_flush, pc_sel_exc} !== 5'b11110) begin
        miscompares++;
        $display("[TB] FAIL exc_drain_c%0d: got %b want 11110", c, {ifid_flush, idex_flush, exmem_flush, memwb_flush, pc_sel_exc});
      end
      tick();
    end
    mem_exc = 1; dmem_stall = 0;
    @(negedge clk);
    vectors++;
    if ({pc_sel_exc, ifid_flush, idex_flush} !== 3'b110) begin
      miscompares++;
      $display("[TB] FAIL exc_redirect: got %b want 110", {pc_sel_exc, ifid_flush, idex_flush});
    end
    tick();
    clear_inputs();
    @(negedge clk);
    vectors++;
    if (obs !== 13'd0) begin
      miscompares++;
      $display("[TB] FAIL exc_back_to_run: got %b want %b", obs, 13'd0);
    end
    tick();
  endtask

  task automatic test_exception_fast();
    clear_inputs();
    mem_exc = 1;
    tick();
    mem_exc = 0;
    @(negedge clk);
    vectors++;
    if (pc_sel_exc !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL exc_one_cycle: got pc_sel_exc=%b want 1", pc_sel_exc);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (pc_sel_exc !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL exc_single_pulse: got pc_sel_exc=%b want 0", pc_sel_exc);
    end
    tick();
  endtask

  task automatic test_reset_in_drain();
    clear_inputs();
    mem_exc = 1; dmem_stall = 1;
    tick();
    mem_exc = 0;
    @(negedge clk);
    vectors++;
    if (memwb_flush !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rst_drain_entered: got memwb_flush=%b want 1", memwb_flush);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (obs !== 13'd0) begin
      miscompares++;
      $display("[TB] FAIL rst_drain_gated: got %b want %b", obs, 13'd0);
    end
    tick();
    rst_n = 1'b1;
    clear_inputs();
    @(negedge clk);
    vectors++;
    if (obs !== 13'd0 || stall_cycles !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL rst_drain_cleared: got %b cnt=%0d want %b cnt=0", obs, stall_cycles, 13'd0);
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      random_inputs();
      rst_n = ($urandom_range(63) != 0);
      @(negedge clk);
      exp_v = model_outputs();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("[TB] FAIL random_ctrl #%0d: got %b want %b", n, obs, exp_v);
      end
      vectors++;
      if (stall_cycles !== m_stalls) begin
        miscompares++;
        $display("[TB] FAIL random_count #%0d: got %0d want %0d", n, stall_cycles, m_stalls);
      end
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_phase     = PH_FLOW;
    m_stalls    = 32'd0;
    rst_n       = 1'b0;
    clear_inputs();
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch_priority();
    test_exception_drain();
    test_exception_fast();
    test_reset_in_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
